// File: rtl/lsu_mem_stage.sv
// Load/store unit behind the ALU: one word-aligned request per load or store,
// with byte-lane store masking and sign/zero-extending load extraction.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state, nxt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, sd_q;
  logic [7:0]  cnt;

  logic        launch, ld_ok, st_ok, mis, bad, expire;
  logic        st_n;
  logic [2:0]  f3_n;
  logic [31:0] a_n, sd_n;
  logic [1:0]  off, ro;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  logic        busy_d, done_d, fault_d, req_d, we_d;
  logic [31:0] ld_d, maddr_d, wdata_d;
  logic [3:0]  wmask_d;

  always_comb begin
    launch = (state == IDLE) && start && (is_load ^ is_store);
    ld_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
             (funct3 == 3'b010) || (funct3 == 3'b100) ||
             (funct3 == 3'b101);
    st_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
             (funct3 == 3'b010);
    mis    = ((funct3[1:0] == 2'b01) && addr[0]) ||
             ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad    = !(is_load ? ld_ok : st_ok) || mis;
    expire = (cnt + 8'd1) == TO_LIM;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (launch) nxt = bad ? DONE : REQ;
      REQ: begin
        if (mem_gnt)     nxt = st_q ? DONE : WAIT;
        else if (expire) nxt = DONE;
      end
      WAIT: if (mem_rvalid || expire) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Fields are taken from the inputs on the launch edge so the registered
  // request is already correct in the first REQ cycle.
  always_comb begin
    st_n  = launch ? is_store   : st_q;
    f3_n  = launch ? funct3     : f3_q;
    a_n   = launch ? addr       : addr_q;
    sd_n  = launch ? store_data : sd_q;
    off   = a_n[1:0];

    unique case (1'b1)
      f3_n[1:0] == 2'b00: begin
        wmask_d = 4'b0001 << off;
        wdata_d = {4{sd_n[7:0]}};
      end
      f3_n[1:0] == 2'b01: begin
        wmask_d = 4'b0011 << off;
        wdata_d = {2{sd_n[15:0]}};
      end
      default: begin
        wmask_d = 4'b1111;
        wdata_d = sd_n;
      end
    endcase

    req_d   = (nxt == REQ);
    we_d    = req_d && st_n;
    maddr_d = req_d ? {a_n[31:2], 2'b00} : 32'd0;
    if (!we_d) begin
      wmask_d = 4'b0000;
      wdata_d = 32'd0;
    end

    ro    = addr_q[1:0];
    rbyte = mem_rdata[{ro, 3'b000} +: 8];
    rhalf = mem_rdata[{ro[1], 4'b0000} +: 16];
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{rbyte[7]}}, rbyte};
      f3_q == 3'b001: ext = {{16{rhalf[15]}}, rhalf};
      f3_q == 3'b100: ext = {24'd0, rbyte};
      f3_q == 3'b101: ext = {16'd0, rhalf};
      default:        ext = mem_rdata;
    endcase

    done_d  = (nxt == DONE);
    busy_d  = (nxt != IDLE);
    ld_d    = (state == WAIT && mem_rvalid) ? ext : 32'd0;
    fault_d = done_d && ((state == IDLE) ||
                         (state == REQ && !mem_gnt) ||
                         (state == WAIT && !mem_rvalid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      sd_q      <= 32'd0;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
    end else begin
      state <= nxt;
      if (launch) begin
        st_q   <= is_store;
        f3_q   <= funct3;
        addr_q <= addr;
        sd_q   <= store_data;
        cnt    <= 8'd0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      load_data <= ld_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= wdata_d;
      mem_wmask <= wmask_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, stores, faults, timeout and
// reset in flight, with a small memory responder driven per transaction.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst, start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // lat counts edges from the launch edge (inclusive) to done being visible
  task automatic xact(input logic ld, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rd, input int gdly,
                      output int lat, output logic [31:0] ldv,
                      output logic flt, output int reqc,
                      output logic [31:0] ma, output logic [31:0] wd,
                      output logic [3:0] wm, output logic we,
                      output logic stable, output logic req_at_done);
    int gc;
    logic granted, got;
    lat = 0; reqc = 0; gc = 0; granted = 0; got = 0;
    ldv = '0; flt = 0; ma = '0; wd = '0; wm = '0; we = 0;
    stable = 1; req_at_done = 0;
    @(negedge clk);
    start = 1; is_load = ld; is_store = !ld;
    funct3 = f3; addr = a; store_data = sd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      start = 0; is_load = 0; is_store = 0;
      mem_gnt = 0; mem_rvalid = 0;
      if (done) begin
        got = 1; ldv = load_data; flt = fault; req_at_done = mem_req;
      end else if (mem_req) begin
        if (reqc == 0) begin
          ma = mem_addr; wd = mem_wdata; wm = mem_wmask; we = mem_we;
        end else if ({mem_addr, mem_wdata, mem_wmask, mem_we} !=
                     {ma, wd, wm, we}) begin
          stable = 0;
        end
        reqc++;
        if (gc == gdly) begin
          mem_gnt = 1; granted = 1;
        end else begin
          gc++;
        end
      end else if (granted) begin
        mem_rvalid = 1; mem_rdata = rd;
      end
    end
    chk("bounded", 32'(got), 32'd1);
  endtask

  task automatic ld_case(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp);
    int lat, reqc;
    logic [31:0] ldv, ma, wd;
    logic [3:0] wm;
    logic flt, we, stb, rad;
    xact(1'b1, f3, a, 32'd0, rd, 0, lat, ldv, flt, reqc, ma, wd, wm, we,
         stb, rad);
    chk({tag, "_data"}, ldv, exp);
    chk({tag, "_fault"}, 32'(flt), 32'd0);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_addr"}, ma, {a[31:2], 2'b00});
    chk({tag, "_we"}, 32'(we), 32'd0);
  endtask

  task automatic st_case(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int gdly, input logic [31:0] exp_wd,
                         input logic [3:0] exp_wm);
    int lat, reqc;
    logic [31:0] ldv, ma, wd;
    logic [3:0] wm;
    logic flt, we, stb, rad;
    xact(1'b0, f3, a, sd, 32'd0, gdly, lat, ldv, flt, reqc, ma, wd, wm, we,
         stb, rad);
    chk({tag, "_addr"}, ma, {a[31:2], 2'b00});
    chk({tag, "_we"}, 32'(we), 32'd1);
    chk({tag, "_wmask"}, 32'(wm), 32'(exp_wm));
    chk({tag, "_wdata"}, wd, exp_wd);
    chk({tag, "_reqc"}, 32'(reqc), 32'(gdly + 1));
    chk({tag, "_stable"}, 32'(stb), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(gdly + 2));
    chk({tag, "_fault"}, 32'(flt), 32'd0);
    chk({tag, "_ldata"}, ldv, 32'd0);
  endtask

  task automatic flt_case(input string tag, input logic ld,
                          input logic [2:0] f3, input logic [31:0] a);
    int lat, reqc;
    logic [31:0] ldv, ma, wd;
    logic [3:0] wm;
    logic flt, we, stb, rad;
    xact(ld, f3, a, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, ldv, flt, reqc,
         ma, wd, wm, we, stb, rad);
    chk({tag, "_fault"}, 32'(flt), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_noreq"}, 32'(reqc), 32'd0);
    chk({tag, "_ldata"}, ldv, 32'd0);
  endtask

  initial begin
    int lat, reqc;
    logic [31:0] ldv, ma, wd;
    logic [3:0] wm;
    logic flt, we, stb, rad, seen;

    rst = 1; start = 0; is_load = 0; is_store = 0; funct3 = 0;
    addr = 0; store_data = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    rst = 0;

    ld_case("lb3", 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    ld_case("lhu2", 3'b101, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF);
    ld_case("lh2", 3'b001, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_80FF);
    ld_case("lw0", 3'b010, 32'h0000_1000, 32'h80FF_1234, 32'h80FF_1234);
    ld_case("lbu1", 3'b100, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);
    ld_case("lb2", 3'b000, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF);
    ld_case("lh0", 3'b001, 32'h0000_1000, 32'h80FF_9234, 32'hFFFF_9234);

    st_case("sh2", 3'b001, 32'h0000_2002, 32'h0000_ABCD, 3,
            32'hABCD_ABCD, 4'b1100);
    st_case("sb1", 3'b000, 32'h0000_2001, 32'h0000_005A, 0,
            32'h5A5A_5A5A, 4'b0010);
    st_case("sw4", 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 1,
            32'hDEAD_BEEF, 4'b1111);

    flt_case("lw_mis", 1'b1, 3'b010, 32'h0000_1001);
    flt_case("sh_mis", 1'b0, 3'b001, 32'h0000_3003);
    flt_case("ld_f3", 1'b1, 3'b011, 32'h0000_1000);
    flt_case("st_f3", 1'b0, 3'b100, 32'h0000_1000);

    xact(1'b1, 3'b010, 32'h0000_1000, 32'd0, 32'd0, 1000, lat, ldv, flt,
         reqc, ma, wd, wm, we, stb, rad);
    chk("to_fault", 32'(flt), 32'd1);
    chk("to_reqc", 32'(reqc), 32'd8);
    chk("to_lat", 32'(lat), 32'd9);
    chk("to_reqdrop", 32'(rad), 32'd0);
    chk("to_ldata", ldv, 32'd0);
    ld_case("post_to", 3'b010, 32'h0000_1008, 32'h1234_5678, 32'h1234_5678);

    @(negedge clk);
    start = 1; is_load = 1; funct3 = 3'b010; addr = 32'h0000_1000;
    @(negedge clk);
    start = 0; is_load = 0;
    chk("rw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rw_busy", 32'(busy), 32'd1);
    start = 1; is_store = 1; funct3 = 3'b010; addr = 32'h0000_4000;
    @(negedge clk);
    start = 0; is_store = 0;
    chk("busy_start_ign", 32'(mem_req), 32'd0);
    chk("busy_still", 32'(busy), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rw_rst_busy", 32'(busy), 32'd0);
    chk("rw_rst_req", 32'(mem_req), 32'd0);
    chk("rw_rst_done", 32'(done), 32'd0);
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 0;
    seen = 0;
    repeat (3) begin
      seen = seen | done | busy;
      @(negedge clk);
    end
    chk("late_rvalid_ign", 32'(seen), 32'd0);
    ld_case("post_rst", 3'b010, 32'h0000_100C, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
